fxu_reservation_station: RTL
============================

FXU_RESERVATION_STATION -- requirements
Module: fxu_reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of reservation entries (supported value: 4 only).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_instr_valid  input  1  dispatch request from instruction buffer.
REQ-005 SHALL have port in_rob_idx  input  4  ROB tag of dispatched instruction.
REQ-006 SHALL have ports in_a_valid / in_b_valid  input  1 each  operand ready at dispatch.
REQ-007 SHALL have ports in_a_value / in_b_value  input  16 each  operand value, meaningful when the matching valid is 1.
REQ-008 SHALL have ports in_a_owner / in_b_owner  input  4 each  producer ROB tag when the operand is not ready.
REQ-009 SHALL have port in_opcode  input  4  FXU opcode.
REQ-010 SHALL have port in_i  input  8  immediate.
REQ-011 SHALL have port full  output  1  no free entry; dispatcher must not send.
REQ-012 SHALL have port rob_output_valid_flat  input  16  ROB result-valid bits; tag k at bit [15-k].
REQ-013 SHALL have port rob_output_values_flat  input  256  ROB results; tag k at bits [16*(15-k)+15 : 16*(15-k)].
REQ-014 SHALL have port exec_ready  input  1  FXU pipeline accepts an issue this cycle.
REQ-015 SHALL have port out_valid  output  1  an entry with both operands ready is presented.
REQ-016 SHALL have ports out_rob_idx 4, out_opcode 4, out_a_value 16, out_b_value 16, out_i 8  output  issued instruction fields.

Function
REQ-017 Each entry SHALL hold: busy, rob_idx, opcode, imm, a_rdy, a_val, a_tag, b_rdy, b_val, b_tag, age (2 bits).
REQ-018 full SHALL be derived from registered state only: 1 when all DEPTH entries are busy; no same-cycle credit for an issue.
REQ-019 Dispatch SHALL occur at posedge when in_instr_valid=1 and full=0, into the lowest-index non-busy entry; in_instr_valid while full=1 SHALL be ignored (entry state unchanged).
REQ-020 At dispatch, an operand with in_x_valid=0 whose owner tag has rob_output_valid=1 that cycle SHALL be captured as ready with the ROB value (no missed wakeup).
REQ-021 Every cycle, each busy entry operand with rdy=0 and rob_output_valid[tag]=1 SHALL set rdy=1 and latch rob_output_values[tag] at posedge.
REQ-022 out_valid SHALL be combinational from registered entries: 1 iff some busy entry has a_rdy=1 and b_rdy=1; a newly written or woken entry becomes issuable the cycle after the write edge.
REQ-023 Selection SHALL be oldest-ready: the ready entry with the smallest age; out_* fields SHALL come from that entry, and SHALL be 0 when out_valid=0.
REQ-024 Issue SHALL complete at posedge when out_valid=1 and exec_ready=1: the selected entry is freed; busy entries with larger age decrement age by 1.
REQ-025 A dispatched entry SHALL receive age = number of busy entries remaining after the same-edge issue removal.
REQ-026 Simultaneous dispatch and issue in one cycle SHALL both take effect; the freed slot is not reused on that edge.
REQ-027 out_valid=1 with exec_ready=0 SHALL hold the same selection unless an older entry becomes ready.

Reset
REQ-028 reset=1 at posedge SHALL clear all busy bits, ages, and ready bits; full=0 and out_valid=0 the following cycle; reset SHALL override any simultaneous dispatch or issue.
REQ-029 Reset mid-operation SHALL discard all held instructions; no issue occurs on the reset edge.

Structure
REQ-030 A shared package rs_pkg SHALL define RS_DEPTH=4, ROB_TAG_W=4, DATA_W=16, OPCODE_W=4, IMM_W=8 and the entry struct type.
REQ-031 One sub-module rs_entry SHALL implement a single slot (storage, wakeup snoop, age update); the top SHALL instantiate DEPTH copies plus the allocate/select logic.

Verification
REQ-032 Dispatch tag 3, opcode 1, a=5 and b=7 both valid, exec_ready=1 -> next cycle out_valid=1, out_rob_idx=3, out_a_value=5, out_b_value=7; one cycle later out_valid=0.
REQ-033 Dispatch tag 2 with a not ready, owner 9; three cycles later rob_output_valid bit for tag 9 = 1, value 0x00AA -> out_valid=1 the following cycle with out_a_value=0x00AA.
REQ-034 Dispatch with owner 9 on the same cycle tag 9 becomes valid -> entry issuable next cycle with the captured value (same-cycle capture).
REQ-035 exec_ready=0, four ready dispatches with tags 0,1,2,3 -> full=1; a fifth dispatch is dropped; raising exec_ready issues tags 0,1,2,3 in order and full falls after the first issue.
REQ-036 Entries tags 4 (not ready) then 5 (ready) -> tag 5 issues first; after 4 wakes it issues next.
REQ-037 With 3 entries busy, assert reset together with a dispatch -> next cycle full=0, out_valid=0, and no later issue of any of those tags.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types and ROB snoop helpers for the FXU reservation station.
package rs_pkg;

  localparam int RS_DEPTH  = 4;
  localparam int ROB_TAG_W = 4;
  localparam int DATA_W    = 16;
  localparam int OPCODE_W  = 4;
  localparam int IMM_W     = 8;
  localparam int AGE_W     = 2;
  localparam int IDX_W     = 2;

  typedef struct packed {
    logic                 busy;
    logic [ROB_TAG_W-1:0] rob_idx;
    logic [OPCODE_W-1:0]  opcode;
    logic [IMM_W-1:0]     imm;
    logic                 a_rdy;
    logic [DATA_W-1:0]    a_val;
    logic [ROB_TAG_W-1:0] a_tag;
    logic                 b_rdy;
    logic [DATA_W-1:0]    b_val;
    logic [ROB_TAG_W-1:0] b_tag;
    logic [AGE_W-1:0]     age;
  } rs_entry_t;

  // ROB flat buses are packed with tag 0 in the most significant slot.
  function automatic logic rob_valid_of(input logic [15:0] flat, input logic [ROB_TAG_W-1:0] tag);
    logic [ROB_TAG_W-1:0] pos;
    pos = 4'd15 - tag;
    return flat[pos];
  endfunction

  function automatic logic [DATA_W-1:0] rob_value_of(input logic [255:0] flat,
                                                     input logic [ROB_TAG_W-1:0] tag);
    logic [ROB_TAG_W-1:0] pos;
    pos = 4'd15 - tag;
    return flat[{pos, 4'b0000} +: DATA_W];
  endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation slot: holds an instruction, snoops ROB results for its
// missing operands, and tracks its relative age.
module rs_entry
  import rs_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         alloc,
  input  logic         issue,
  input  logic         dec_age,
  input  rs_entry_t    alloc_data,
  input  logic [15:0]  rob_valid_flat,
  input  logic [255:0] rob_values_flat,
  output rs_entry_t    state
);

  rs_entry_t next_s;

  // Snoop runs on the post-allocation view so a result arriving on the
  // dispatch cycle is never missed.
  always_comb begin
    next_s = state;
    if (alloc) begin
      next_s = alloc_data;
    end else if (issue) begin
      next_s.busy  = 1'b0;
      next_s.a_rdy = 1'b0;
      next_s.b_rdy = 1'b0;
      next_s.age   = 2'd0;
    end else if (dec_age) begin
      next_s.age = state.age - 2'd1;
    end else begin
      next_s = state;
    end

    if (next_s.busy && !next_s.a_rdy && rob_valid_of(rob_valid_flat, next_s.a_tag)) begin
      next_s.a_rdy = 1'b1;
      next_s.a_val = rob_value_of(rob_values_flat, next_s.a_tag);
    end else begin
      next_s.a_rdy = next_s.a_rdy;
    end

    if (next_s.busy && !next_s.b_rdy && rob_valid_of(rob_valid_flat, next_s.b_tag)) begin
      next_s.b_rdy = 1'b1;
      next_s.b_val = rob_value_of(rob_values_flat, next_s.b_tag);
    end else begin
      next_s.b_rdy = next_s.b_rdy;
    end
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
    end else begin
      state <= next_s;
    end
  end

endmodule

// File: rtl/fxu_reservation_station.sv
// FXU reservation station: lowest-free-slot allocation, ROB wakeup and
// oldest-ready issue selection over DEPTH rs_entry slots.
module fxu_reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_instr_valid,
  input  logic [ROB_TAG_W-1:0] in_rob_idx,
  input  logic                 in_a_valid,
  input  logic                 in_b_valid,
  input  logic [DATA_W-1:0]    in_a_value,
  input  logic [DATA_W-1:0]    in_b_value,
  input  logic [ROB_TAG_W-1:0] in_a_owner,
  input  logic [ROB_TAG_W-1:0] in_b_owner,
  input  logic [OPCODE_W-1:0]  in_opcode,
  input  logic [IMM_W-1:0]     in_i,
  output logic                 full,
  input  logic [15:0]          rob_output_valid_flat,
  input  logic [255:0]         rob_output_values_flat,
  input  logic                 exec_ready,
  output logic                 out_valid,
  output logic [ROB_TAG_W-1:0] out_rob_idx,
  output logic [OPCODE_W-1:0]  out_opcode,
  output logic [DATA_W-1:0]    out_a_value,
  output logic [DATA_W-1:0]    out_b_value,
  output logic [IMM_W-1:0]     out_i
);

  rs_entry_t        entries [DEPTH];
  rs_entry_t        new_entry_s;
  logic [DEPTH-1:0] busy_s, ready_s, alloc_s, issue_s, dec_s;
  logic [IDX_W-1:0] sel_idx_s, alloc_idx_s;
  logic [AGE_W-1:0] sel_age_s, busy_cnt_s;
  logic             sel_found_s, alloc_found_s, do_dispatch_s, do_issue_s;

  // Status vectors, occupancy count and lowest free slot.
  always_comb begin
    busy_s        = '0;
    ready_s       = '0;
    busy_cnt_s    = 2'd0;
    alloc_found_s = 1'b0;
    alloc_idx_s   = 2'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      busy_s[i]  = entries[i].busy;
      ready_s[i] = entries[i].busy && entries[i].a_rdy && entries[i].b_rdy;
      busy_cnt_s = busy_cnt_s + {1'b0, entries[i].busy};
      if (!entries[i].busy) begin
        alloc_found_s = 1'b1;
        alloc_idx_s   = i[IDX_W-1:0];
      end else begin
        alloc_found_s = alloc_found_s;
      end
    end
  end

  // Oldest-ready selection; ages of busy slots are unique.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = 2'd0;
    sel_age_s   = 2'd3;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_s[i] && (!sel_found_s || entries[i].age < sel_age_s)) begin
        sel_found_s = 1'b1;
        sel_idx_s   = i[IDX_W-1:0];
        sel_age_s   = entries[i].age;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  assign full          = &busy_s;
  assign do_dispatch_s = in_instr_valid && !full && alloc_found_s;
  assign do_issue_s    = sel_found_s && exec_ready;

  // New slot contents; its age counts survivors of a same-edge issue.
  always_comb begin
    new_entry_s         = '0;
    new_entry_s.busy    = 1'b1;
    new_entry_s.rob_idx = in_rob_idx;
    new_entry_s.opcode  = in_opcode;
    new_entry_s.imm     = in_i;
    new_entry_s.a_rdy   = in_a_valid;
    new_entry_s.a_val   = in_a_valid ? in_a_value : 16'h0000;
    new_entry_s.a_tag   = in_a_owner;
    new_entry_s.b_rdy   = in_b_valid;
    new_entry_s.b_val   = in_b_valid ? in_b_value : 16'h0000;
    new_entry_s.b_tag   = in_b_owner;
    new_entry_s.age     = busy_cnt_s - {1'b0, do_issue_s};
  end

  // Per-slot control strobes.
  always_comb begin
    alloc_s = '0;
    issue_s = '0;
    dec_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_s[i] = do_dispatch_s && (alloc_idx_s == i[IDX_W-1:0]);
      issue_s[i] = do_issue_s && (sel_idx_s == i[IDX_W-1:0]);
      dec_s[i]   = do_issue_s && busy_s[i] && (entries[i].age > sel_age_s);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    rs_entry u_entry (
      .clk             (clk),
      .reset           (reset),
      .alloc           (alloc_s[g]),
      .issue           (issue_s[g]),
      .dec_age         (dec_s[g]),
      .alloc_data      (new_entry_s),
      .rob_valid_flat  (rob_output_valid_flat),
      .rob_values_flat (rob_output_values_flat),
      .state           (entries[g])
    );
  end

  // Issue port, zeroed when nothing is ready.
  always_comb begin
    out_valid = sel_found_s;
    if (sel_found_s) begin
      out_rob_idx = entries[sel_idx_s].rob_idx;
      out_opcode  = entries[sel_idx_s].opcode;
      out_a_value = entries[sel_idx_s].a_val;
      out_b_value = entries[sel_idx_s].b_val;
      out_i       = entries[sel_idx_s].imm;
    end else begin
      out_rob_idx = 4'd0;
      out_opcode  = 4'd0;
      out_a_value = 16'h0000;
      out_b_value = 16'h0000;
      out_i       = 8'h00;
    end
  end

endmodule
